ysyx_24110015_ifu: RTL

YSYX_24110015_IFU -- requirements
Module: ysyx_24110015_IFU

---
 rtl/ysyx_24110015_ifu.sv | 94 +++++++++
 1 files changed

// File: rtl/ysyx_24110015_ifu.sv
// Instruction fetch: one outstanding read, 1 REQ + N WAIT cycles to inst_valid, timeout after TIMEOUT-1 WAIT cycles.
// Backpressure: inst/pc_o/fetch_err hold in HOLD until inst_ready; no new fetch until a pc_update is accepted.
module ysyx_24110015_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    input  logic        pc_update,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rerr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc_o,
    output logic        fetch_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_WAIT_PC
    } state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc;
    logic [CW-1:0]   cnt;
    logic            pc_acc;
    logic            misalign;
    logic            timeout;

    // A redirect is taken while parked in WAIT_PC, or together with the HOLD handshake.
    assign pc_acc   = pc_update & ((state == S_WAIT_PC) | ((state == S_HOLD) & inst_ready));
    assign misalign = pc_next[1:0] != 2'b00;
    // The counter reaches TIMEOUT-1 at the end of this WAIT cycle.
    assign timeout  = (state == S_WAIT) & (cnt == CW'(TIMEOUT - 2));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = S_REQ;
            S_REQ:     state_nxt = S_WAIT;
            S_WAIT:    if (imem_rvalid || timeout) state_nxt = S_HOLD;
            S_HOLD: begin
                if (inst_ready) begin
                    if (pc_acc) state_nxt = misalign ? S_HOLD : S_REQ;
                    else        state_nxt = S_WAIT_PC;
                end
            end
            S_WAIT_PC: if (pc_update) state_nxt = misalign ? S_HOLD : S_REQ;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (pc_acc)               pc  <= pc_next;
            if (state == S_REQ)       cnt <= '0;
            else if (state == S_WAIT) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst      <= '0;
            fetch_err <= 1'b0;
        end else if ((state == S_WAIT) && imem_rvalid) begin
            inst      <= imem_rerr ? 32'h0 : imem_rdata;
            fetch_err <= imem_rerr;
        end else if (timeout || (pc_acc && misalign)) begin
            inst      <= '0;
            fetch_err <= 1'b1;
        end
    end

    assign imem_req   = (state == S_REQ);
    assign imem_addr  = pc;
    assign inst_valid = (state == S_HOLD);
    assign pc_o       = pc;

endmodule
